// File: rtl/typedefs_pkg.sv
// Shared types for the ALU and its issue unit: ALU op selects, instruction classes,
// issue FSM states and the RISC-V funct3 encodings the issue unit decodes.
package typedefs_pkg;

    typedef enum logic [2:0] {
        ALU_AND = 3'd0,
        ALU_OR  = 3'd1,
        ALU_ADD = 3'd2,
        ALU_SUB = 3'd6,
        ALU_SLT = 3'd7
    } aluop_sel_t;

    typedef enum logic [1:0] {
        ALU_R  = 2'd0,
        ALU_I  = 2'd1,
        BRANCH = 2'd2,
        MEM    = 2'd3
    } alu_class_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } issue_state_t;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;

endpackage

// File: rtl/alu_issue_dec.sv
// Combinational decode of (class, funct3, funct7[5]) into an ALU op select.
// Illegal encodings map to ADD and raise the illegal flag.
module alu_issue_dec
    import typedefs_pkg::*;
(
    input  alu_class_t op_class,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output aluop_sel_t sel,
    output logic       illegal
);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        sel     = ALU_ADD;
        illegal = 1'b0;
        case (op_class)
            ALU_R, ALU_I: begin
                case (funct3)
                    F3_ADD_SUB: sel = (op_class == ALU_R && funct7b5) ? ALU_SUB : ALU_ADD;
                    F3_AND:     sel = ALU_AND;
                    F3_OR:      sel = ALU_OR;
                    F3_SLT:     sel = ALU_SLT;
                    default:    illegal = 1'b1;
                endcase
            end
            BRANCH: begin
                if (funct3 == F3_BEQ || funct3 == F3_BNE) begin
                    sel = ALU_SUB;
                end else begin
                    illegal = 1'b1;
                end
            end
            MEM:     sel = ALU_ADD;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_unit.sv
// Issues one decoded op to the combinational ALU per valid/ready handshake and returns
// result, zero flag and branch decision. Define ALU_ISSUE_ERR_EN to add the out_err port.
module alu_issue_unit
    import typedefs_pkg::*;
#(
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  alu_class_t        in_class,
    input  logic [2:0]        in_funct3,
    input  logic              in_funct7b5,
    input  logic [DWIDTH-1:0] in_a,
    input  logic [DWIDTH-1:0] in_b,
    output aluop_sel_t        alu_sel,
    output logic [DWIDTH-1:0] alu_src1,
    output logic [DWIDTH-1:0] alu_src2,
    input  logic [DWIDTH-1:0] alu_res,
    input  logic              alu_res_is_0,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_res,
    output logic              out_zero,
    output logic              out_br_taken
`ifdef ALU_ISSUE_ERR_EN
    ,output logic             out_err
`endif
);

    issue_state_t      state, state_nxt;
    aluop_sel_t        dec_sel, sel_q;
    alu_class_t        class_q;
    logic [2:0]        f3_q;
    logic [DWIDTH-1:0] a_q, b_q;
    logic              accept;
    logic [DWIDTH-1:0] cap_res;
    logic              cap_zero, cap_br;

`ifdef ALU_ISSUE_ERR_EN
    logic dec_illegal, err_q;
`else
    logic unused_illegal;
`endif

    alu_issue_dec u_dec (
        .op_class (in_class),
        .funct3   (in_funct3),
        .funct7b5 (in_funct7b5),
        .sel      (dec_sel),
`ifdef ALU_ISSUE_ERR_EN
        .illegal  (dec_illegal)
`else
        .illegal  (unused_illegal)
`endif
    );

    assign accept = in_valid & in_ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = in_valid ? EXEC : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE) || (state == DONE && out_ready);
        out_valid = (state == DONE);
        alu_sel   = sel_q;
        alu_src1  = a_q;
        alu_src2  = b_q;
    end

    // Operation latch; reset values make the idle ALU see AND of zeros.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q   <= ALU_AND;
            class_q <= ALU_R;
            f3_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
`ifdef ALU_ISSUE_ERR_EN
            err_q   <= 1'b0;
`endif
        end else if (accept) begin
            sel_q   <= dec_sel;
            class_q <= in_class;
            f3_q    <= in_funct3;
            a_q     <= in_a;
            b_q     <= in_b;
`ifdef ALU_ISSUE_ERR_EN
            err_q   <= dec_illegal;
`endif
        end
    end

    always_comb begin
        cap_res  = alu_res;
        cap_zero = alu_res_is_0;
        cap_br   = 1'b0;
        if (class_q == BRANCH) begin
            if (f3_q == F3_BEQ)      cap_br = alu_res_is_0;
            else if (f3_q == F3_BNE) cap_br = ~alu_res_is_0;
        end
`ifdef ALU_ISSUE_ERR_EN
        // An illegal op still completes, but with a fixed neutral result.
        if (err_q) begin
            cap_res  = '0;
            cap_zero = 1'b1;
            cap_br   = 1'b0;
        end
`endif
    end

    // Result registers only change on the EXEC edge, so they hold through backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_res      <= '0;
            out_zero     <= 1'b0;
            out_br_taken <= 1'b0;
`ifdef ALU_ISSUE_ERR_EN
            out_err      <= 1'b0;
`endif
        end else if (state == EXEC) begin
            out_res      <= cap_res;
            out_zero     <= cap_zero;
            out_br_taken <= cap_br;
`ifdef ALU_ISSUE_ERR_EN
            out_err      <= err_q;
`endif
        end
    end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed-vector bench for alu_issue_unit with a behavioural ALU attached; results are
// checked by a scoreboard monitor that pops an expectation on every output handshake.
module tb_alu_issue_unit;
    import typedefs_pkg::*;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    alu_class_t    in_class;
    logic [2:0]    in_funct3;
    logic          in_funct7b5;
    logic [DW-1:0] in_a, in_b;
    aluop_sel_t    alu_sel;
    logic [DW-1:0] alu_src1, alu_src2;
    logic [DW-1:0] alu_res;
    logic          alu_res_is_0;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_res;
    logic          out_zero;
    logic          out_br_taken;
`ifdef ALU_ISSUE_ERR_EN
    logic          out_err;
`endif

    typedef struct {
        logic [DW-1:0] res;
        logic          zero;
        logic          br;
        logic          err;
        string         name;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    alu_issue_unit #(.DWIDTH(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_class     (in_class),
        .in_funct3    (in_funct3),
        .in_funct7b5  (in_funct7b5),
        .in_a         (in_a),
        .in_b         (in_b),
        .alu_sel      (alu_sel),
        .alu_src1     (alu_src1),
        .alu_src2     (alu_src2),
        .alu_res      (alu_res),
        .alu_res_is_0 (alu_res_is_0),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_res      (out_res),
        .out_zero     (out_zero),
        .out_br_taken (out_br_taken)
`ifdef ALU_ISSUE_ERR_EN
        ,.out_err     (out_err)
`endif
    );

    // Behavioural ALU attached to the issue unit.
    always_comb begin
        case (alu_sel)
            ALU_AND: alu_res = alu_src1 & alu_src2;
            ALU_OR:  alu_res = alu_src1 | alu_src2;
            ALU_ADD: alu_res = alu_src1 + alu_src2;
            ALU_SUB: alu_res = alu_src1 - alu_src2;
            ALU_SLT: alu_res = ($signed(alu_src1) < $signed(alu_src2)) ? 8'd1 : 8'd0;
            default: alu_res = 8'hA5;
        endcase
        alu_res_is_0 = (alu_res == '0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: pops and compares on every completed output handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("alu_sel_legal",
                      {31'd0, alu_sel inside {ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT}}, 32'd1);
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_result", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check({e.name, "_res"},  {24'd0, out_res},  {24'd0, e.res});
                        check({e.name, "_zero"}, {31'd0, out_zero}, {31'd0, e.zero});
                        check({e.name, "_br"},   {31'd0, out_br_taken}, {31'd0, e.br});
`ifdef ALU_ISSUE_ERR_EN
                        check({e.name, "_err"},  {31'd0, out_err},  {31'd0, e.err});
`endif
                    end
                end
            end
        end
    end

    task automatic drive_op(input alu_class_t c, input logic [2:0] f3, input logic f7,
                            input logic [DW-1:0] a, input logic [DW-1:0] b);
        in_valid    = 1'b1;
        in_class    = c;
        in_funct3   = f3;
        in_funct7b5 = f7;
        in_a        = a;
        in_b        = b;
    endtask

    task automatic push_exp(input string name, input logic [DW-1:0] r, input logic z,
                            input logic br, input logic err);
        exp_t e;
        e.res = r; e.zero = z; e.br = br; e.err = err; e.name = name;
        sb.push_back(e);
    endtask

    // Issues one op with out_ready high, checks decode and two-cycle latency. Call at posedge+1.
    task automatic issue(input string name, input alu_class_t c, input logic [2:0] f3,
                         input logic f7, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input aluop_sel_t esel, input logic [DW-1:0] eres, input logic ez,
                         input logic ebr, input logic eerr);
        int n = 0;
        drive_op(c, f3, f7, a, b);
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check({name, "_ready_timeout"}, 32'd0, 32'd1);
            @(posedge clk); #1 in_valid = 1'b0;
            return;
        end
        push_exp(name, eres, ez, ebr, eerr);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        check({name, "_sel"},  {29'd0, alu_sel}, {29'd0, esel});
        check({name, "_src1"}, {24'd0, alu_src1}, {24'd0, a});
        check({name, "_lat_exec"}, {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check({name, "_lat_done"}, {31'd0, out_valid}, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        drive_op(ALU_R, 3'b000, 1'b0, 8'h00, 8'h00);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_res",   {24'd0, out_res},   32'd0);
        check("rst_out_zero",  {31'd0, out_zero},  32'd0);
        check("rst_out_br",    {31'd0, out_br_taken}, 32'd0);
        check("rst_alu_sel",   {29'd0, alu_sel},   32'd0);
        check("rst_src",       {16'd0, alu_src1, alu_src2}, 32'd0);
`ifdef ALU_ISSUE_ERR_EN
        check("rst_out_err",   {31'd0, out_err},   32'd0);
`endif
        rst = 1'b0;
        @(posedge clk); #1;

        issue("r_add",  ALU_R, 3'b000, 1'b0, 8'h05, 8'h03, ALU_ADD, 8'h08, 1'b0, 1'b0, 1'b0);
        issue("r_sub",  ALU_R, 3'b000, 1'b1, 8'h07, 8'h07, ALU_SUB, 8'h00, 1'b1, 1'b0, 1'b0);
        issue("i_add",  ALU_I, 3'b000, 1'b1, 8'h07, 8'h07, ALU_ADD, 8'h0E, 1'b0, 1'b0, 1'b0);
        issue("r_and",  ALU_R, 3'b111, 1'b0, 8'hF0, 8'h3C, ALU_AND, 8'h30, 1'b0, 1'b0, 1'b0);
        issue("i_or",   ALU_I, 3'b110, 1'b0, 8'hF0, 8'h0C, ALU_OR,  8'hFC, 1'b0, 1'b0, 1'b0);
        issue("r_slt",  ALU_R, 3'b010, 1'b0, 8'h80, 8'h01, ALU_SLT, 8'h01, 1'b0, 1'b0, 1'b0);
        issue("mem",    MEM,   3'b010, 1'b1, 8'h20, 8'h04, ALU_ADD, 8'h24, 1'b0, 1'b0, 1'b0);
        issue("beq_t",  BRANCH, 3'b000, 1'b0, 8'h10, 8'h10, ALU_SUB, 8'h00, 1'b1, 1'b1, 1'b0);
        issue("bne_t",  BRANCH, 3'b001, 1'b0, 8'h10, 8'h11, ALU_SUB, 8'hFF, 1'b0, 1'b1, 1'b0);
        issue("beq_nt", BRANCH, 3'b000, 1'b0, 8'h10, 8'h11, ALU_SUB, 8'hFF, 1'b0, 1'b0, 1'b0);
`ifdef ALU_ISSUE_ERR_EN
        issue("r_ill",  ALU_R,  3'b011, 1'b0, 8'h05, 8'h03, ALU_ADD, 8'h00, 1'b1, 1'b0, 1'b1);
        issue("br_ill", BRANCH, 3'b100, 1'b0, 8'h10, 8'h10, ALU_ADD, 8'h00, 1'b1, 1'b0, 1'b1);
`else
        issue("r_ill",  ALU_R,  3'b011, 1'b0, 8'h05, 8'h03, ALU_ADD, 8'h08, 1'b0, 1'b0, 1'b0);
        issue("br_ill", BRANCH, 3'b100, 1'b0, 8'h10, 8'h10, ALU_ADD, 8'h20, 1'b0, 1'b0, 1'b0);
`endif

        // Backpressure: result must hold while out_ready stays low.
        out_ready = 1'b0;
        drive_op(ALU_R, 3'b110, 1'b0, 8'h0F, 8'h30);
        @(negedge clk);
        check("bp_idle_ready", {31'd0, in_ready}, 32'd1);
        push_exp("bp_or", 8'h3F, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1 in_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid_seen", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            check("bp_hold_ready", {31'd0, in_ready},  32'd0);
            check("bp_hold_res",   {24'd0, out_res},   32'h3F);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        drive_op(ALU_R, 3'b000, 1'b0, 8'h11, 8'h22);
        push_exp("b2b_add", 8'h33, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("b2b_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        check("b2b_exec_valid", {31'd0, out_valid}, 32'd0);
        check("b2b_exec_sel",   {29'd0, alu_sel},   {29'd0, ALU_ADD});
        @(negedge clk);
        check("b2b_done_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk); #1;

        // Reset during EXEC aborts the op; no result may appear afterwards.
        drive_op(ALU_R, 3'b000, 1'b0, 8'h01, 8'h01);
        @(posedge clk); #1 in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_in_ready",  {31'd0, in_ready},  32'd1);
        check("abort_alu_sel",   {29'd0, alu_sel},   32'd0);
        check("abort_out_res",   {24'd0, out_res},   32'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_result", {31'd0, out_valid}, 32'd0);
        end
        @(posedge clk); #1;
        issue("post_rst", ALU_I, 3'b111, 1'b0, 8'h5A, 8'h0F, ALU_AND, 8'h0A, 1'b0, 1'b0, 1'b0);

        repeat (5) @(posedge clk);
        #1;
        check("sb_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
